// File: rtl/toy_mem_responder.sv
// toy_mem_responder: shared word-addressed memory serving the RISC_TOY
// instruction and data buses, each port with its own fixed read latency.
// Ports: CLK/RST (async active-high), IREQ/IADDR -> INSTR/IERR,
//        DREQ/DRW/DADDR/DWDATA -> DRDATA/DERR, LD_* backdoor preload, WCNT.

// toy_mem_rd_pipe: valid-tracked read-data delay line of LAT stages feeding
// a registered output that only changes when a valid entry retires.
// Ports: req/err_in/dat_in enter stage 0; dat_out holds, err_out pulses.
module toy_mem_rd_pipe #(
   parameter int LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        err_in,
   input  logic [31:0] dat_in,
   output logic [31:0] dat_out,
   output logic        err_out
);

   logic [LAT-1:0] vld;
   logic [LAT-1:0] err;
   logic [31:0]    dat [LAT];

   // Only the valid bits are reset; payload is qualified by vld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else begin
         vld[0] <= req;
         for (int k = 1; k < LAT; k++) begin
            vld[k] <= vld[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      dat[0] <= dat_in;
      err[0] <= err_in;
      for (int k = 1; k < LAT; k++) begin
         dat[k] <= dat[k-1];
         err[k] <= err[k-1];
      end
   end

   // Retirement: data output holds unless the last stage carries a valid
   // entry; an errored entry forces zero data and a one-cycle err pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dat_out <= '0;
         err_out <= 1'b0;
      end else begin
         err_out <= vld[LAT-1] & err[LAT-1];
         if (vld[LAT-1]) begin
            dat_out <= err[LAT-1] ? 32'h0 : dat[LAT-1];
         end
      end
   end

endmodule

module toy_mem_responder #(
   parameter int AW    = 10,
   parameter int I_LAT = 1,
   parameter int D_LAT = 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IREQ,
   input  logic [29:0]   IADDR,
   output logic [31:0]   INSTR,
   output logic          IERR,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [29:0]   DADDR,
   input  logic [31:0]   DWDATA,
   output logic [31:0]   DRDATA,
   output logic          DERR,
   input  logic          LD_EN,
   input  logic [AW-1:0] LD_ADDR,
   input  logic [31:0]   LD_DATA,
   output logic [15:0]   WCNT
);

   localparam int DEPTH = 1 << AW;

   // Elaboration-time configuration checks.
   if (I_LAT < 1 || I_LAT > 4) begin : g_bad_i_lat
      $error("toy_mem_responder: I_LAT must be in 1..4");
   end
   if (D_LAT < 1 || D_LAT > 4) begin : g_bad_d_lat
      $error("toy_mem_responder: D_LAT must be in 1..4");
   end
   if (AW < 1 || AW > 29) begin : g_bad_aw
      $error("toy_mem_responder: AW must be in 1..29");
   end

   logic [31:0]   mem [DEPTH];

   logic          i_inr;
   logic          d_inr;
   logic          d_wr;
   logic          wen;
   logic [AW-1:0] waddr;
   logic [31:0]   wdat;
   logic          d_commit;
   logic          d_drop;
   logic [31:0]   i_rd;
   logic [31:0]   d_rd;
   logic          drop_s1;
   logic          drop_s2;
   logic          d_ret_err;

   assign i_inr = (IADDR[29:AW] == '0);
   assign d_inr = (DADDR[29:AW] == '0);
   assign d_wr  = DREQ & DRW;

   // Single write port: the backdoor load always wins, so a same-cycle bus
   // write is dropped regardless of its address.
   assign d_commit = d_wr & d_inr & ~LD_EN;
   assign d_drop   = d_wr & (LD_EN | ~d_inr);
   assign wen      = LD_EN | d_commit;
   assign waddr    = LD_EN ? LD_ADDR : DADDR[AW-1:0];
   assign wdat     = LD_EN ? LD_DATA : DWDATA;

   always_ff @(posedge CLK) begin
      if (wen) begin
         mem[waddr] <= wdat;
      end
   end

   // Write-first: a read of the word being written this edge sees new data.
   always_comb begin
      i_rd = mem[IADDR[AW-1:0]];
      if (wen && (waddr == IADDR[AW-1:0])) begin
         i_rd = wdat;
      end
      d_rd = mem[DADDR[AW-1:0]];
      if (wen && (waddr == DADDR[AW-1:0])) begin
         d_rd = wdat;
      end
   end

   toy_mem_rd_pipe #(.LAT(I_LAT)) u_i_pipe (
      .clk     (CLK),
      .rst     (RST),
      .req     (IREQ),
      .err_in  (~i_inr),
      .dat_in  (i_rd),
      .dat_out (INSTR),
      .err_out (IERR)
   );

   toy_mem_rd_pipe #(.LAT(D_LAT)) u_d_pipe (
      .clk     (CLK),
      .rst     (RST),
      .req     (DREQ & ~DRW),
      .err_in  (~d_inr),
      .dat_in  (d_rd),
      .dat_out (DRDATA),
      .err_out (d_ret_err)
   );

   // A dropped write is reported one edge after it was presented, the same
   // timing as a one-cycle read retirement.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         drop_s1 <= 1'b0;
         drop_s2 <= 1'b0;
      end else begin
         drop_s1 <= d_drop;
         drop_s2 <= drop_s1;
      end
   end

   // Both sources are registers, so the OR merges overlapping events into a
   // single clean one-cycle pulse.
   assign DERR = d_ret_err | drop_s2;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         WCNT <= '0;
      end else if (d_commit && (WCNT != 16'hFFFF)) begin
         WCNT <= WCNT + 16'd1;
      end
   end

endmodule

// File: tb/tb_toy_mem_responder.sv
// tb_toy_mem_responder: drives two responders (different latencies) with the
// same directed stimulus and compares every output each cycle against a
// scoreboard of expected retirements, dropped-write pulses and write count.
module tb_toy_mem_responder;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IREQ;
   logic [29:0] IADDR;
   logic        DREQ;
   logic        DRW;
   logic [29:0] DADDR;
   logic [31:0] DWDATA;
   logic        LD_EN;
   logic [9:0]  LD_ADDR;
   logic [31:0] LD_DATA;

   logic [31:0] a_instr, a_drdata, b_instr, b_drdata;
   logic        a_ierr, a_derr, b_ierr, b_derr;
   logic [15:0] a_wcnt, b_wcnt;

   always #5 CLK = ~CLK;

   // dut_a: I_LAT=1, D_LAT=3.  dut_b: I_LAT=2, D_LAT=4.
   toy_mem_responder #(.AW(10), .I_LAT(1), .D_LAT(3)) dut_a (
      .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(a_instr), .IERR(a_ierr),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(a_drdata), .DERR(a_derr),
      .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .WCNT(a_wcnt)
   );

   toy_mem_responder #(.AW(10), .I_LAT(2), .D_LAT(4)) dut_b (
      .CLK(CLK), .RST(RST), .IREQ(IREQ), .IADDR(IADDR), .INSTR(b_instr), .IERR(b_ierr),
      .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(b_drdata), .DERR(b_derr),
      .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA), .WCNT(b_wcnt)
   );

   typedef struct {
      int          due;
      logic [31:0] dat;
      logic        err;
   } ent_t;

   // Port index: 0 a.I, 1 a.D, 2 b.I, 3 b.D
   ent_t        q [4][$];
   int          drops [$];
   logic [31:0] held [4];
   int          lat [4] = '{1, 3, 2, 4};
   string       names [4] = '{"a_instr", "a_drdata", "b_instr", "b_drdata"};
   logic [31:0] mem_m [1024];
   logic [15:0] wcnt_m;
   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s @edge %0d: observed %h expected %h", tag, edge_n, obs, exp_v);
      end
   endtask

   task automatic check_outputs();
      logic        drop_now;
      logic [31:0] exp_dat;
      logic        exp_err;
      logic [31:0] obs_dat;
      logic        obs_err;
      ent_t        e;
      drop_now = 1'b0;
      while (drops.size() > 0 && drops[0] <= edge_n) begin
         if (drops[0] == edge_n) drop_now = 1'b1;
         void'(drops.pop_front());
      end
      for (int p = 0; p < 4; p++) begin
         exp_dat = held[p];
         exp_err = 1'b0;
         if (q[p].size() > 0 && q[p][0].due == edge_n) begin
            e       = q[p].pop_front();
            exp_dat = e.err ? 32'h0 : e.dat;
            exp_err = e.err;
            held[p] = exp_dat;
         end
         if (p == 1 || p == 3) exp_err = exp_err | drop_now;
         case (p)
            0:       begin obs_dat = a_instr;  obs_err = a_ierr; end
            1:       begin obs_dat = a_drdata; obs_err = a_derr; end
            2:       begin obs_dat = b_instr;  obs_err = b_ierr; end
            default: begin obs_dat = b_drdata; obs_err = b_derr; end
         endcase
         chk(names[p], obs_dat, exp_dat);
         chk({names[p], "_err"}, {31'b0, obs_err}, {31'b0, exp_err});
      end
      chk("a_wcnt", {16'b0, a_wcnt}, {16'b0, wcnt_m});
      chk("b_wcnt", {16'b0, b_wcnt}, {16'b0, wcnt_m});
   endtask

   // Apply the currently driven inputs to the model for the coming edge,
   // queue the expected retirements, then clock and compare.
   task automatic tick();
      int   n;
      ent_t e;
      n = edge_n + 1;
      if (RST) begin
         for (int p = 0; p < 4; p++) begin
            q[p].delete();
            held[p] = 32'h0;
         end
         drops.delete();
         wcnt_m = 16'h0;
      end else begin
         if (LD_EN) begin
            mem_m[LD_ADDR] = LD_DATA;
            if (DREQ && DRW) drops.push_back(n + 1);
         end else if (DREQ && DRW) begin
            if (DADDR[29:10] == 20'h0) begin
               mem_m[DADDR[9:0]] = DWDATA;
               if (wcnt_m != 16'hFFFF) wcnt_m = wcnt_m + 16'd1;
            end else begin
               drops.push_back(n + 1);
            end
         end
         if (IREQ) begin
            e.err = (IADDR[29:10] != 20'h0);
            e.dat = mem_m[IADDR[9:0]];
            e.due = n + lat[0]; q[0].push_back(e);
            e.due = n + lat[2]; q[2].push_back(e);
         end
         if (DREQ && !DRW) begin
            e.err = (DADDR[29:10] != 20'h0);
            e.dat = mem_m[DADDR[9:0]];
            e.due = n + lat[1]; q[1].push_back(e);
            e.due = n + lat[3]; q[3].push_back(e);
         end
      end
      @(posedge CLK);
      #1;
      edge_n = n;
      check_outputs();
   endtask

   task automatic idle();
      IREQ = 0; IADDR = '0; DREQ = 0; DRW = 0; DADDR = '0; DWDATA = '0;
      LD_EN = 0; LD_ADDR = '0; LD_DATA = '0;
   endtask

   task automatic idle_n(input int cnt);
      idle();
      for (int i = 0; i < cnt; i++) tick();
   endtask

   task automatic ld(input logic [9:0] a, input logic [31:0] d);
      idle(); LD_EN = 1; LD_ADDR = a; LD_DATA = d; tick();
   endtask

   initial begin
      RST = 1'b1;
      idle();
      wcnt_m = '0;
      for (int p = 0; p < 4; p++) held[p] = 32'h0;
      // Reset state
      tick();
      tick();
      RST = 1'b0;
      idle_n(2);

      // Preload + fetch
      for (int i = 0; i < 4; i++) ld(10'(i), 32'h1111_0000 + i);
      ld(10'd7, 32'h0);
      ld(10'd9, 32'h9999_0009);
      for (int i = 0; i < 4; i++) begin
         idle(); IREQ = 1; IADDR = 30'(i); tick();
      end
      idle_n(4);
      // Simultaneous I and D read of the same word
      idle(); IREQ = 1; IADDR = 30'd1; DREQ = 1; DADDR = 30'd1; tick();
      idle_n(5);

      // Write then read
      idle(); DREQ = 1; DRW = 1; DADDR = 30'd5; DWDATA = 32'hDEAD_BEEF; tick();
      idle(); DREQ = 1; DADDR = 30'd5; tick();
      idle_n(6);

      // Write-first collision on the I port, and via backdoor on the D port
      idle(); DREQ = 1; DRW = 1; DADDR = 30'd7; DWDATA = 32'hA5A5_A5A5; IREQ = 1; IADDR = 30'd7; tick();
      idle(); LD_EN = 1; LD_ADDR = 10'd3; LD_DATA = 32'h3333_3333; DREQ = 1; DADDR = 30'd3; tick();
      idle_n(6);

      // Out of range read, then out of range write landing on the same
      // DERR cycle as dut_a's errored retirement
      idle(); DREQ = 1; DADDR = 30'h400; tick();
      idle_n(1);
      idle(); DREQ = 1; DRW = 1; DADDR = 30'h400; DWDATA = 32'h5555_5555; tick();
      idle(); IREQ = 1; IADDR = 30'h400; tick();
      idle_n(6);

      // Backdoor priority over a same-edge bus write
      idle(); LD_EN = 1; LD_ADDR = 10'd2; LD_DATA = 32'h1; DREQ = 1; DRW = 1; DADDR = 30'd9; DWDATA = 32'h2; tick();
      idle(); IREQ = 1; IADDR = 30'd2; DREQ = 1; DADDR = 30'd9; tick();
      idle_n(6);

      // Reset mid-flight
      idle(); DREQ = 1; DADDR = 30'd5; tick();
      idle_n(1);
      RST = 1'b1;
      idle_n(1);
      RST = 1'b0;
      idle_n(7);
      idle(); DREQ = 1; DADDR = 30'd0; IREQ = 1; IADDR = 30'd3; tick();
      idle_n(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
